// File: rtl/rps_arbiter.sv
// rps_arbiter: rotating-priority arbiter, NUM_REQ requesters.
// Free-running or round-robin pointer, per-requester grant lock.
module rps_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int PTR_W = $clog2(NUM_REQ)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] lock,
  input  logic               en,
  input  logic               mode,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic [PTR_W-1:0]   count
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   ptr_n;
  logic [PTR_W-1:0]   win;
  logic [PTR_W-1:0]   idx_n;
  logic [NUM_REQ-1:0] gnt_n;
  logic               valid_n;
  logic               found;
  logic               held;
  logic               sel_scan;
  logic               sel_none;

  function automatic logic [PTR_W-1:0] wrap_inc(
    input logic [PTR_W-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // gnt is one-hot, so any live bit of gnt&req&lock is the held grant
  assign held     = en & |(gnt & req & lock);
  assign sel_scan = en & ~held & found;
  assign sel_none = ~held & ~sel_scan;
  assign count    = ptr;

  // circular scan from ptr for the first active request
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[PTR_W'(j)]) begin
        found = 1'b1;
        win   = PTR_W'(j);
      end
    end
  end

  // next grant and pointer selection
  always_comb begin
    gnt_n   = '0;
    idx_n   = gnt_idx;
    valid_n = 1'b0;
    ptr_n   = ptr;
    unique case (1'b1)
      held: begin
        gnt_n   = gnt;
        valid_n = 1'b1;
      end
      sel_scan: begin
        gnt_n[win] = 1'b1;
        idx_n      = win;
        valid_n    = 1'b1;
      end
      sel_none: ;
      default: ;
    endcase
    if (!mode)
      ptr_n = wrap_inc(ptr);
    else if (sel_scan)
      ptr_n = wrap_inc(win);
  end

  // registered grant outputs and pointer
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr       <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
    end else begin
      ptr       <= ptr_n;
      gnt       <= gnt_n;
      gnt_idx   <= idx_n;
      gnt_valid <= valid_n;
    end
  end

endmodule

// File: tb/tb_rps_arbiter.sv
// tb_rps_arbiter: directed scenarios plus randomized
// traffic against a reference model, NUM_REQ=4 and 5.
module tb_rps_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;

  logic [3:0] r4 = '0, l4 = '0, g4;
  logic       en4 = 1'b0, md4 = 1'b0, gv4;
  logic [1:0] gi4, c4;

  logic [4:0] r5 = '0, l5 = '0, g5;
  logic       en5 = 1'b0, md5 = 1'b0, gv5;
  logic [2:0] gi5, c5;

  int vec = 0;
  int errs = 0;

  int m_n[2] = '{4, 5};
  int m_ptr[2];
  int m_idx[2];
  bit m_val[2];

  always #5 clock = ~clock;

  rps_arbiter #(.NUM_REQ(4)) u4 (
    .clock(clock), .reset(reset),
    .req(r4), .lock(l4), .en(en4), .mode(md4),
    .gnt(g4), .gnt_idx(gi4),
    .gnt_valid(gv4), .count(c4)
  );

  rps_arbiter #(.NUM_REQ(5)) u5 (
    .clock(clock), .reset(reset),
    .req(r5), .lock(l5), .en(en5), .mode(md5),
    .gnt(g5), .gnt_idx(gi5),
    .gnt_valid(gv5), .count(c5)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cyc4(
    input logic [3:0] r, input logic [3:0] l,
    input logic e, input logic m
  );
    r4 = r; l4 = l; en4 = e; md4 = m;
    tick();
  endtask

  task automatic cyc5(
    input logic [4:0] r, input logic [4:0] l,
    input logic e, input logic m
  );
    r5 = r; l5 = l; en5 = e; md5 = m;
    tick();
  endtask

  task automatic do_reset();
    r4 = '0; l4 = '0; en4 = 0; md4 = 0;
    r5 = '0; l5 = '0; en5 = 0; md5 = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_ptr[u] = 0;
      m_idx[u] = 0;
      m_val[u] = 0;
    end
  endtask

  // spec rules: lock hold, circular scan, mode-based pointer update
  task automatic model_step(
    input int u, input logic [4:0] r,
    input logic [4:0] l, input logic e, input logic m
  );
    int n;
    bit hold;
    int w;
    int np;
    n = m_n[u];
    hold = e && m_val[u] && r[m_idx[u]] && l[m_idx[u]];
    w = -1;
    if (!hold)
      for (int k = 0; k < n; k++)
        if (w < 0 && r[(m_ptr[u] + k) % n])
          w = (m_ptr[u] + k) % n;
    if (!m)
      np = (m_ptr[u] + 1) % n;
    else if (e && !hold && w >= 0)
      np = (w + 1) % n;
    else
      np = m_ptr[u];
    if (!e)
      m_val[u] = 0;
    else if (hold)
      m_val[u] = 1;
    else if (w >= 0) begin
      m_val[u] = 1;
      m_idx[u] = w;
    end else
      m_val[u] = 0;
    m_ptr[u] = np;
  endtask

  task automatic test_reset();
    logic [8:0] e4;
    logic [11:0] e5;
    do_reset();
    reset = 1'b1;
    r4 = '1; l4 = '1; en4 = 1; md4 = 1;
    r5 = '1; l5 = '1; en5 = 1; md5 = 1;
    tick();
    reset = 1'b0;
    e4 = '0;
    e5 = '0;
    vec++;
    if ({g4, gv4, gi4, c4} !== e4) begin
      errs++;
      $display("FAIL reset4 got %b exp %b",
               {g4, gv4, gi4, c4}, e4);
    end
    vec++;
    if ({g5, gv5, gi5, c5} !== e5) begin
      errs++;
      $display("FAIL reset5 got %b exp %b",
               {g5, gv5, gi5, c5}, e5);
    end
  endtask

  task automatic test_free_rotation();
    logic [3:0] eg[4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [1:0] ec[4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [8:0] e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc4(4'b1111, 4'b0000, 1, 0);
      e = {eg[i], 1'b1, 2'(i), ec[i]};
      vec++;
      if ({g4, gv4, gi4, c4} !== e) begin
        errs++;
        $display("FAIL free_rot%0d got %b exp %b",
                 i, {g4, gv4, gi4, c4}, e);
      end
    end
  endtask

  task automatic test_free_scan_wrap();
    logic [8:0] e;
    do_reset();
    cyc4(4'b0000, 4'b0000, 0, 0);
    cyc4(4'b0000, 4'b0000, 0, 0);
    cyc4(4'b1011, 4'b0000, 1, 0);
    e = {4'b1000, 1'b1, 2'd3, 2'd3};
    vec++;
    if ({g4, gv4, gi4, c4} !== e) begin
      errs++;
      $display("FAIL free_scan_a got %b exp %b",
               {g4, gv4, gi4, c4}, e);
    end
    cyc4(4'b1011, 4'b0000, 1, 0);
    e = {4'b1000, 1'b1, 2'd3, 2'd0};
    vec++;
    if ({g4, gv4, gi4, c4} !== e) begin
      errs++;
      $display("FAIL free_scan_b got %b exp %b",
               {g4, gv4, gi4, c4}, e);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg[3] = '{4'b0010, 4'b1000, 4'b0010};
    logic [1:0] ei[3] = '{2'd1, 2'd3, 2'd1};
    logic [1:0] ec[3] = '{2'd2, 2'd0, 2'd2};
    logic [8:0] e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc4(4'b1010, 4'b0000, 1, 1);
      e = {eg[i], 1'b1, ei[i], ec[i]};
      vec++;
      if ({g4, gv4, gi4, c4} !== e) begin
        errs++;
        $display("FAIL rr%0d got %b exp %b",
                 i, {g4, gv4, gi4, c4}, e);
      end
    end
  endtask

  task automatic test_lock();
    logic [8:0] e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc4(4'b1111, 4'b0001, 1, 1);
      e = {4'b0001, 1'b1, 2'd0, 2'd1};
      vec++;
      if ({g4, gv4, gi4, c4} !== e) begin
        errs++;
        $display("FAIL lock_hold%0d got %b exp %b",
                 i, {g4, gv4, gi4, c4}, e);
      end
    end
    cyc4(4'b1111, 4'b0000, 1, 1);
    e = {4'b0010, 1'b1, 2'd1, 2'd2};
    vec++;
    if ({g4, gv4, gi4, c4} !== e) begin
      errs++;
      $display("FAIL lock_drop got %b exp %b",
               {g4, gv4, gi4, c4}, e);
    end
    cyc4(4'b1111, 4'b0001, 1, 1);
    e = {4'b0100, 1'b1, 2'd2, 2'd3};
    vec++;
    if ({g4, gv4, gi4, c4} !== e) begin
      errs++;
      $display("FAIL lock_nogrant got %b exp %b",
               {g4, gv4, gi4, c4}, e);
    end
  endtask

  task automatic test_enable();
    logic [8:0] e;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      cyc4(4'b1111, 4'b0000, 0, 0);
      e = {4'b0000, 1'b0, 2'd0, 2'(i + 1)};
      vec++;
      if ({g4, gv4, gi4, c4} !== e) begin
        errs++;
        $display("FAIL en_off%0d got %b exp %b",
                 i, {g4, gv4, gi4, c4}, e);
      end
    end
    cyc4(4'b1111, 4'b0000, 1, 0);
    e = {4'b0100, 1'b1, 2'd2, 2'd3};
    vec++;
    if ({g4, gv4, gi4, c4} !== e) begin
      errs++;
      $display("FAIL en_on got %b exp %b",
               {g4, gv4, gi4, c4}, e);
    end
    cyc4(4'b1111, 4'b1111, 0, 1);
    e = {4'b0000, 1'b0, 2'd2, 2'd3};
    vec++;
    if ({g4, gv4, gi4, c4} !== e) begin
      errs++;
      $display("FAIL en_hold_idx got %b exp %b",
               {g4, gv4, gi4, c4}, e);
    end
  endtask

  task automatic test_five_wrap();
    logic [11:0] e;
    do_reset();
    cyc5(5'b10000, 5'b00000, 1, 1);
    e = {5'b10000, 1'b1, 3'd4, 3'd0};
    vec++;
    if ({g5, gv5, gi5, c5} !== e) begin
      errs++;
      $display("FAIL five_a got %b exp %b",
               {g5, gv5, gi5, c5}, e);
    end
    cyc5(5'b00001, 5'b00000, 1, 1);
    e = {5'b00001, 1'b1, 3'd0, 3'd1};
    vec++;
    if ({g5, gv5, gi5, c5} !== e) begin
      errs++;
      $display("FAIL five_b got %b exp %b",
               {g5, gv5, gi5, c5}, e);
    end
    reset = 1'b1;
    cyc5(5'b00001, 5'b00001, 1, 1);
    reset = 1'b0;
    e = '0;
    vec++;
    if ({g5, gv5, gi5, c5} !== e) begin
      errs++;
      $display("FAIL five_reset got %b exp %b",
               {g5, gv5, gi5, c5}, e);
    end
  endtask

  task automatic test_random();
    logic [8:0]  e4;
    logic [11:0] e5;
    bit rs;
    do_reset();
    model_reset();
    for (int i = 0; i < 600; i++) begin
      rs  = ($urandom_range(0, 59) == 0);
      r4  = 4'($urandom);
      l4  = 4'($urandom);
      en4 = ($urandom_range(0, 7) != 0);
      md4 = 1'($urandom);
      r5  = 5'($urandom) & 5'($urandom | $urandom);
      l5  = 5'($urandom);
      en5 = ($urandom_range(0, 7) != 0);
      md5 = 1'($urandom);
      reset = rs;
      if (rs)
        model_reset();
      else begin
        model_step(0, {1'b0, r4}, {1'b0, l4}, en4, md4);
        model_step(1, r5, l5, en5, md5);
      end
      tick();
      reset = 1'b0;
      e4 = {m_val[0] ? 4'(1 << m_idx[0]) : 4'b0,
            m_val[0], 2'(m_idx[0]), 2'(m_ptr[0])};
      e5 = {m_val[1] ? 5'(1 << m_idx[1]) : 5'b0,
            m_val[1], 3'(m_idx[1]), 3'(m_ptr[1])};
      vec++;
      if ({g4, gv4, gi4, c4} !== e4) begin
        errs++;
        $display("FAIL rand4 cyc %0d got %b exp %b",
                 i, {g4, gv4, gi4, c4}, e4);
      end
      vec++;
      if ({g5, gv5, gi5, c5} !== e5) begin
        errs++;
        $display("FAIL rand5 cyc %0d got %b exp %b",
                 i, {g5, gv5, gi5, c5}, e5);
      end
    end
  endtask

  initial begin
    tick();
    tick();
    test_reset();
    test_free_rotation();
    test_free_scan_wrap();
    test_round_robin();
    test_lock();
    test_enable();
    test_five_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vec, errs);
    $finish;
  end

endmodule
